// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one single-ported fixed-latency memory between
// the I-fetch and D ports. Optional macro ARB_FAIRNESS_EN bounds D streaks.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int MEM_LATENCY  = 2,
  parameter int MAX_D_STREAK = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_read,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_data,
  output logic                 d_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] c_cnt_init = 4'(MEM_LATENCY - 1);

  generate
    if (MEM_LATENCY < 1 || MEM_LATENCY > 15 || MAX_D_STREAK < 1) begin : g_bad_params
      $error("mem_port_arbiter: MEM_LATENCY must be 1..15 and MAX_D_STREAK >= 1");
    end
  endgenerate

  state_t                 r_state;
  state_t                 w_next_state;
  logic   [3:0]           r_cnt;
  logic                   r_owner_d;
  logic                   r_op_write;
  logic   [WORD_SIZE-1:0] r_mem_addr;
  logic   [WORD_SIZE-1:0] r_mem_wdata;
  logic   [WORD_SIZE-1:0] r_i_data;
  logic   [WORD_SIZE-1:0] r_d_data;

  logic w_d_req;
  logic w_any_req;
  logic w_force_i;
  logic w_grant_d;
  logic w_grant_write;
  logic w_grant;

  assign w_d_req   = d_read | d_write;
  assign w_any_req = w_d_req | i_read;
  assign w_grant   = (r_state == ST_IDLE) && w_any_req;

`ifdef ARB_FAIRNESS_EN
  localparam int c_streak_w = (MAX_D_STREAK < 2) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_D_STREAK);

  logic [c_streak_w-1:0] r_streak;

  // A saturated streak hands the next slot to a waiting fetch.
  assign w_force_i = i_read && (r_streak == c_streak_max);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_streak <= '0;
    end else if (w_grant) begin
      if (!w_grant_d || !i_read) begin
        r_streak <= '0;
      end else if (r_streak != c_streak_max) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end
`else
  assign w_force_i = 1'b0;
`endif

  assign w_grant_d     = w_d_req && !w_force_i;
  assign w_grant_write = w_grant_d && d_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_ready      = 1'b0;
    d_ready      = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        busy      = 1'b1;
        mem_read  = !r_op_write;
        mem_write = r_op_write;
        if (r_cnt == 4'd0) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        busy         = 1'b1;
        i_ready      = !r_owner_d;
        d_ready      = r_owner_d;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Address, data and op are captured at grant so requester changes during ACCESS are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= 4'd0;
      r_owner_d   <= 1'b0;
      r_op_write  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_data    <= '0;
      r_d_data    <= '0;
    end else if (w_grant) begin
      r_cnt       <= c_cnt_init;
      r_owner_d   <= w_grant_d;
      r_op_write  <= w_grant_write;
      r_mem_addr  <= w_grant_d ? d_addr : i_addr;
      r_mem_wdata <= w_grant_write ? d_wdata : '0;
    end else if (r_state == ST_ACCESS) begin
      if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (!r_op_write) begin
        if (r_owner_d) begin
          r_d_data <= mem_rdata;
        end else begin
          r_i_data <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_data    = r_i_data;
  assign d_data    = r_d_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : scoreboard bench for mem_port_arbiter with a
// fixed-latency memory model. Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

  localparam int W   = 16;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         i_read, d_read, d_write;
  logic [W-1:0] i_addr, d_addr, d_wdata;
  logic [W-1:0] i_data, d_data, mem_addr, mem_wdata, mem_rdata;
  logic         i_ready, d_ready, mem_read, mem_write, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(LAT), .MAX_D_STREAK(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_data(d_data), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory model: default contents 0xA000+addr (0x10 holds 0x1234); data valid only in last read cycle.
  logic [W-1:0] wmem [0:255];
  logic [255:0] written = '0;
  logic [3:0]   rd_cnt;
  logic [W-1:0] base_word;

  always @(posedge clk) begin
    if (mem_write) begin
      wmem[mem_addr[7:0]]    <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)      rd_cnt <= 4'd0;
    else if (mem_read) rd_cnt <= rd_cnt + 4'd1;
    else               rd_cnt <= 4'd0;
  end

  assign base_word = (mem_addr[7:0] == 8'h10) ? 16'h1234 : (16'hA000 + {8'h00, mem_addr[7:0]});
  assign mem_rdata = (mem_read && rd_cnt == 4'(LAT - 1)) ?
                     (written[mem_addr[7:0]] ? wmem[mem_addr[7:0]] : base_word) : 16'hDEAD;

  typedef struct packed {
    logic         is_d;
    logic [W-1:0] data;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] shadow_d;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0;   d_addr = '0;   d_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 reset_n = 1'b0;
    step(); step();
    n_tests++;
    if ({i_ready, d_ready, mem_read, mem_write, busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {i_ready, d_ready, mem_read, mem_write, busy});
    end
    n_tests++;
    if ({i_data, d_data, mem_addr, mem_wdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {i_data, d_data, mem_addr, mem_wdata});
    end
    @(negedge clk) reset_n = 1'b1;
    shadow_d = '0;
    step();
    n_tests++;
    if (busy !== 1'b0 || mem_read !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req: busy=%b mem_read=%b expected 0 0", busy, mem_read);
    end
  endtask

  task automatic test_single_fetch();
    exp_t e;
    i_addr = 16'h0010; i_read = 1'b1;
    sb.push_back('{1'b0, 16'h1234});
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c <= 2) begin
        n_tests++;
        if (!(mem_read === 1'b1 && mem_write === 1'b0 && mem_addr === 16'h0010 && busy === 1'b1 && i_ready === 1'b0)) begin
          n_fail++; $display("FAIL fetch_access c%0d: rd=%b wr=%b addr=%h busy=%b rdy=%b expected 1 0 0010 1 0",
                             c, mem_read, mem_write, mem_addr, busy, i_ready);
        end
      end else if (c == 3) begin
        n_tests++;
        if (i_ready !== 1'b1 || d_ready !== 1'b0 || mem_read !== 1'b0) begin
          n_fail++; $display("FAIL fetch_ready: i_ready=%b d_ready=%b mem_read=%b expected 1 0 0", i_ready, d_ready, mem_read);
        end else begin
          e = sb.pop_front();
          n_tests++;
          if (i_data !== e.data) begin
            n_fail++; $display("FAIL fetch_data: got %h expected %h", i_data, e.data);
          end
        end
        i_read = 1'b0;
      end else begin
        n_tests++;
        if (i_ready !== 1'b0 || i_data !== 16'h1234 || busy !== 1'b0) begin
          n_fail++; $display("FAIL fetch_after: rdy=%b data=%h busy=%b expected 0 1234 0", i_ready, i_data, busy);
        end
      end
    end
  endtask

  // Issues one D access (write if wr) and checks strobes, ready timing and d_data via the scoreboard.
  task automatic test_d_access(input logic rd, input logic wr, input logic [W-1:0] addr,
                               input logic [W-1:0] wdata, input logic [W-1:0] exp_data);
    exp_t e;
    d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata;
    sb.push_back('{1'b1, exp_data});
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c <= 2) begin
        n_tests++;
        if (mem_write !== wr || mem_read !== !wr || mem_addr !== addr || (wr && mem_wdata !== wdata)) begin
          n_fail++; $display("FAIL d_access c%0d: wr=%b rd=%b addr=%h wdata=%h expected %b %b %h %h",
                             c, mem_write, mem_read, mem_addr, mem_wdata, wr, !wr, addr, wdata);
        end
      end else begin
        n_tests++;
        if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
          n_fail++; $display("FAIL d_ready: d_ready=%b i_ready=%b expected 1 0", d_ready, i_ready);
        end else begin
          e = sb.pop_front();
          n_tests++;
          if (d_data !== e.data) begin
            n_fail++; $display("FAIL d_data %h: got %h expected %h", addr, d_data, e.data);
          end
        end
        d_read = 1'b0; d_write = 1'b0;
      end
    end
    step();
  endtask

  task automatic test_d_write();
    test_d_access(1'b0, 1'b1, 16'h0020, 16'hBEEF, shadow_d);
    test_d_access(1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF);
    shadow_d = 16'hBEEF;
  endtask

  task automatic test_simultaneous();
    exp_t e;
    i_addr = 16'h0030; d_addr = 16'h0040; i_read = 1'b1; d_read = 1'b1;
    sb.push_back('{1'b1, 16'hA040});
    sb.push_back('{1'b0, 16'hA030});
    for (int c = 1; c <= 8; c++) begin
      step();
      n_tests++;
      if (d_ready !== (c == 3) || i_ready !== (c == 7)) begin
        n_fail++; $display("FAIL simul_order c%0d: d_ready=%b i_ready=%b expected %b %b",
                           c, d_ready, i_ready, (c == 3), (c == 7));
      end
      if (d_ready === 1'b1 || i_ready === 1'b1) begin
        e = sb.pop_front();
        n_tests++;
        if (d_ready !== e.is_d || (e.is_d ? d_data : i_data) !== e.data) begin
          n_fail++; $display("FAIL simul_data c%0d: port_d=%b data=%h expected %b %h",
                             c, d_ready, e.is_d ? d_data : i_data, e.is_d, e.data);
        end
        if (d_ready === 1'b1) d_read = 1'b0;
        if (i_ready === 1'b1) i_read = 1'b0;
      end
    end
    i_read = 1'b0; d_read = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    i_addr = 16'h0050; i_read = 1'b1;
    step();
    n_tests++;
    if (mem_read !== 1'b1 || i_data === 16'h0000 || d_data === 16'h0000) begin
      n_fail++; $display("FAIL pre_reset: mem_read=%b i_data=%h d_data=%h expected 1 nonzero nonzero", mem_read, i_data, d_data);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({mem_read, mem_write, busy} !== 3'b0 || i_data !== 16'h0 || d_data !== 16'h0) begin
      n_fail++; $display("FAIL async_reset: strobes/busy=%b i_data=%h d_data=%h expected 000 0000 0000",
                         {mem_read, mem_write, busy}, i_data, d_data);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (i_ready !== 1'b0 || d_ready !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL in_reset c%0d: i_ready=%b d_ready=%b busy=%b expected 0 0 0", c, i_ready, d_ready, busy);
      end
    end
    @(negedge clk) reset_n = 1'b1;
    shadow_d = '0;
    sb.push_back('{1'b0, 16'hA050});
    for (int c = 1; c <= 5; c++) begin
      step();
      n_tests++;
      if (i_ready !== (c == 3)) begin
        n_fail++; $display("FAIL post_reset_ready c%0d: got %b expected %b", c, i_ready, (c == 3));
      end
      if (i_ready === 1'b1) begin
        e = sb.pop_front();
        n_tests++;
        if (i_data !== e.data) begin
          n_fail++; $display("FAIL post_reset_data: got %h expected %h", i_data, e.data);
        end
        i_read = 1'b0;
      end
    end
    i_read = 1'b0;
  endtask

  task automatic test_read_write_both();
    test_d_access(1'b1, 1'b1, 16'h0060, 16'h5A5A, shadow_d);
    test_d_access(1'b1, 1'b0, 16'h0060, 16'h0000, 16'h5A5A);
    shadow_d = 16'h5A5A;
  endtask

  task automatic test_fairness();
    exp_t e;
    int   n_i = 0;
    int   n_d = 0;
    int   i_cycle = 0;
    i_addr = 16'h0070; d_addr = 16'h0080; i_read = 1'b1; d_read = 1'b1;
`ifdef ARB_FAIRNESS_EN
    for (int k = 0; k < 3; k++) sb.push_back('{1'b1, 16'hA080});
    sb.push_back('{1'b0, 16'hA070});
`else
    for (int k = 0; k < 10; k++) sb.push_back('{1'b1, 16'hA080});
`endif
    for (int c = 1; c <= 40; c++) begin
      step();
      if (d_ready === 1'b1 || i_ready === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL fair_extra c%0d: unexpected ready d=%b i=%b", c, d_ready, i_ready);
        end else begin
          e = sb.pop_front();
          if (d_ready !== e.is_d || (e.is_d ? d_data : i_data) !== e.data) begin
            n_fail++; $display("FAIL fair_grant c%0d: port_d=%b data=%h expected %b %h",
                               c, d_ready, e.is_d ? d_data : i_data, e.is_d, e.data);
          end
        end
        if (d_ready === 1'b1) n_d++;
        if (i_ready === 1'b1) begin
          n_i++; i_cycle = c;
          i_read = 1'b0; d_read = 1'b0;
        end
      end
    end
    i_read = 1'b0; d_read = 1'b0;
    step(); step(); step(); step();
    n_tests++;
`ifdef ARB_FAIRNESS_EN
    if (n_i !== 1 || n_d !== 3 || i_cycle !== 15) begin
      n_fail++; $display("FAIL fair_count: i=%0d d=%0d i_cycle=%0d expected 1 3 15", n_i, n_d, i_cycle);
    end
`else
    if (n_i !== 0 || n_d !== 10) begin
      n_fail++; $display("FAIL starve_count: i=%0d d=%0d i_cycle=%0d expected 0 10", n_i, n_d, i_cycle);
    end
`endif
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_d_write();
    test_simultaneous();
    test_reset_mid();
    test_read_write_both();
    test_fairness();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
